// File: rtl/tx_conn_scheduler.sv
// Transmit scheduler: round-robin scan of connection records, packet-builder launch,
// and arbitration of the single RAM port between scheduler, packet builder and host.
module tx_conn_scheduler #(
  parameter int NUM_RECORDS   = 8,
  parameter int RECORD_STRIDE = 32,
  parameter int PB_TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_en,
  input  logic        host_req,
  input  logic [8:0]  host_addr,
  input  logic [31:0] host_wdata,
  input  logic        host_wren,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic [8:0]  ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_wren,
  input  logic [31:0] ram_q,
  output logic        pb_start,
  output logic [7:0]  pb_base,
  input  logic [8:0]  pb_addr,
  input  logic        pb_done,
  output logic        busy,
  output logic [15:0] sent_count,
  output logic        timeout_err
);

  localparam int PTR_W = (NUM_RECORDS > 1) ? $clog2(NUM_RECORDS) : 1;
  localparam int CNT_W = $clog2(PB_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    READ_HDR,
    WAIT_HDR,
    LAUNCH,
    WAIT_PB,
    CLEAR,
    NEXT
  } state_t;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   ptr_reg, ptr_next;
  logic [31:0]        hdr_reg, hdr_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [CNT_W-1:0]   cnt_inc;
  logic [15:0]        sent_reg, sent_next;
  logic               terr_reg, terr_next;
  logic               rvalid_reg, rvalid_next;
  logic [8:0]         base;

  assign base    = 9'(int'(ptr_reg) * RECORD_STRIDE);
  assign cnt_inc = cnt_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      hdr_reg    <= '0;
      cnt_reg    <= '0;
      sent_reg   <= '0;
      terr_reg   <= 1'b0;
      rvalid_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      hdr_reg    <= hdr_next;
      cnt_reg    <= cnt_next;
      sent_reg   <= sent_next;
      terr_reg   <= terr_next;
      rvalid_reg <= rvalid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    hdr_next   = hdr_reg;
    cnt_next   = cnt_reg;
    sent_next  = sent_reg;
    terr_next  = terr_reg;
    host_gnt   = 1'b0;
    pb_start   = 1'b0;
    ram_addr   = base;
    ram_wdata  = '0;
    ram_wren   = 1'b0;

    case (state_reg)
      IDLE: begin
        host_gnt = host_req;
        if (scan_en) state_next = READ_HDR;
      end
      READ_HDR: state_next = WAIT_HDR;
      WAIT_HDR: begin
        hdr_next   = ram_q;
        state_next = (ram_q[31] && ram_q[30]) ? LAUNCH : NEXT;
      end
      LAUNCH: begin
        pb_start   = 1'b1;
        cnt_next   = '0;
        state_next = WAIT_PB;
      end
      WAIT_PB: begin
        ram_addr = pb_addr;
        cnt_next = cnt_inc;
        // A done in the same cycle as the timeout wins.
        if (pb_done) begin
          sent_next  = sent_reg + 16'd1;
          state_next = CLEAR;
        end else if (cnt_inc == CNT_W'(PB_TIMEOUT)) begin
          terr_next  = 1'b1;
          state_next = NEXT;
        end
      end
      CLEAR: begin
        ram_wdata  = hdr_reg & ~32'h4000_0000;
        ram_wren   = 1'b1;
        state_next = NEXT;
      end
      NEXT: begin
        host_gnt   = host_req;
        ptr_next   = ptr_reg + 1'b1;
        state_next = scan_en ? READ_HDR : IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (host_gnt) begin
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
      ram_wren  = host_wren;
    end
    rvalid_next = host_gnt && !host_wren;
  end

  // ptr is constant from LAUNCH until the build completes, so base doubles as pb_base.
  assign pb_base     = base[7:0];
  assign busy        = (state_reg != IDLE);
  assign sent_count  = sent_reg;
  assign timeout_err = terr_reg;
  assign host_rvalid = rvalid_reg;

endmodule

// File: tb/tb_tx_conn_scheduler.sv
// Bench for tx_conn_scheduler: behavioural RAM and packet builder, event monitor,
// and per-scenario tasks comparing scoreboard expectations against observed events.
module tb_tx_conn_scheduler;

  logic        clk;
  logic        reset;
  logic        scan_en;
  logic        host_req;
  logic [8:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_wren;
  logic        host_gnt;
  logic        host_rvalid;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wren;
  logic [31:0] ram_q;
  logic        pb_start;
  logic [7:0]  pb_base;
  logic [8:0]  pb_addr;
  logic        pb_done;
  logic        busy;
  logic [15:0] sent_count;
  logic        timeout_err;

  int tests = 0;
  int errors = 0;
  int cyc = 0;
  int pb_delay = 0;
  int pb_timer = 0;

  logic [31:0] mem [0:511];

  logic [7:0]  exp_launch[$];
  logic [40:0] exp_wr[$];
  logic [31:0] exp_hrd[$];
  logic [8:0]  exp_addr[$];
  logic [7:0]  obs_launch[$];
  int          obs_launch_cyc[$];
  logic [40:0] obs_wr[$];
  int          obs_wr_cyc[$];
  logic [31:0] obs_hrd[$];
  int          obs_hrd_cyc[$];

  tx_conn_scheduler #(.NUM_RECORDS(8), .RECORD_STRIDE(32), .PB_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .scan_en(scan_en),
    .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_wren(host_wren), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q),
    .pb_start(pb_start), .pb_base(pb_base), .pb_addr(pb_addr), .pb_done(pb_done),
    .busy(busy), .sent_count(sent_count), .timeout_err(timeout_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM, read data registered; read returns the pre-write contents.
  always @(posedge clk) begin
    ram_q <= mem[ram_addr];
    if (ram_wren) mem[ram_addr] = ram_wdata;
  end

  // Packet builder: pb_done pulses pb_delay cycles after pb_start; 0 means never.
  assign pb_addr = {1'b0, pb_base} + 9'd1;
  always @(negedge clk) begin
    if (pb_start) begin
      pb_timer = pb_delay;
      pb_done = 1'b0;
    end else if (pb_timer > 0) begin
      pb_timer = pb_timer - 1;
      pb_done = (pb_timer == 0);
    end else begin
      pb_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (pb_start) begin
        obs_launch.push_back(pb_base);
        obs_launch_cyc.push_back(cyc);
      end
      if (ram_wren && !host_gnt) begin
        obs_wr.push_back({ram_addr, ram_wdata});
        obs_wr_cyc.push_back(cyc);
      end
      if (host_rvalid) begin
        obs_hrd.push_back(ram_q);
        obs_hrd_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    scan_en = 1'b0;
    host_req = 1'b0;
    host_wren = 1'b0;
    host_addr = '0;
    host_wdata = '0;
    pb_delay = 0;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    exp_launch.delete(); exp_wr.delete(); exp_hrd.delete(); exp_addr.delete();
    obs_launch.delete(); obs_launch_cyc.delete(); obs_wr.delete(); obs_wr_cyc.delete();
    obs_hrd.delete(); obs_hrd_cyc.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    scan_en = 1'b0;
    host_req = 1'b0;
    host_wren = 1'b0;
    host_addr = '0;
    host_wdata = '0;
    pb_done = 1'b0;
    tick();
    tick();
    tests++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (pb_start !== 1'b0) begin errors++; $display("FAIL reset_pb_start: got %b expected 0", pb_start); end
    tests++; if (host_gnt !== 1'b0 || host_rvalid !== 1'b0) begin errors++; $display("FAIL reset_host: gnt %b rvalid %b expected 0 0", host_gnt, host_rvalid); end
    tests++; if (ram_wren !== 1'b0 || ram_addr !== 9'd0 || ram_wdata !== 32'd0) begin errors++; $display("FAIL reset_ram: wren %b addr %0d wdata %h expected 0 0 0", ram_wren, ram_addr, ram_wdata); end
    tests++; if (pb_base !== 8'd0) begin errors++; $display("FAIL reset_pb_base: got %0d expected 0", pb_base); end
    tests++; if (sent_count !== 16'd0 || timeout_err !== 1'b0) begin errors++; $display("FAIL reset_counters: sent %0d terr %b expected 0 0", sent_count, timeout_err); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_empty_lap();
    logic [8:0] e;
    do_reset();
    for (int k = 0; k < 24; k++) exp_addr.push_back(9'((k / 3) * 32));
    exp_addr.push_back(9'd0);
    scan_en = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      e = exp_addr.pop_front();
      tests++;
      if (ram_addr !== e) begin errors++; $display("FAIL empty_lap_addr[%0d]: got %0d expected %0d", k, ram_addr, e); end
    end
    scan_en = 1'b0;
    for (int k = 0; k < 10 && busy; k++) tick();
    tests++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_lap_idle: busy %b expected 0", busy); end
    tests++; if (obs_launch.size() != 0 || sent_count !== 16'd0) begin errors++; $display("FAIL empty_lap_launch: launches %0d sent %0d expected 0 0", obs_launch.size(), sent_count); end
    $display("[TB] test_empty_lap done");
  endtask

  task automatic test_launch();
    int c0;
    logic [40:0] w;
    bit seen;
    do_reset();
    mem[64] = 32'hC000_0000;
    pb_delay = 10;
    exp_launch.push_back(8'd64);
    exp_wr.push_back({9'd64, 32'h8000_0000});
    c0 = cyc;
    scan_en = 1'b1;
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (obs_wr.size() > 0) begin seen = 1; break; end
    end
    scan_en = 1'b0;
    tests++;
    if (!seen || obs_launch.size() != 1) begin
      errors++; $display("FAIL launch_events: writes %0d launches %0d expected 1 1", obs_wr.size(), obs_launch.size());
    end else begin
      tests++; if (obs_launch[0] !== exp_launch[0]) begin errors++; $display("FAIL launch_base: got %0d expected %0d", obs_launch[0], exp_launch[0]); end
      tests++; if (obs_launch_cyc[0] != c0 + 9) begin errors++; $display("FAIL launch_time: got cycle %0d expected %0d", obs_launch_cyc[0], c0 + 9); end
      w = exp_wr.pop_front();
      tests++; if (obs_wr[0] !== w) begin errors++; $display("FAIL launch_clear_write: got %h expected %h", obs_wr[0], w); end
      tests++; if (obs_wr_cyc[0] - obs_launch_cyc[0] != 11) begin errors++; $display("FAIL launch_clear_time: got %0d expected 11", obs_wr_cyc[0] - obs_launch_cyc[0]); end
    end
    for (int k = 0; k < 10 && busy; k++) tick();
    tests++; if (sent_count !== 16'd1) begin errors++; $display("FAIL launch_sent: got %0d expected 1", sent_count); end
    tests++; if (mem[64] !== 32'h8000_0000 || busy !== 1'b0) begin errors++; $display("FAIL launch_final: mem %h busy %b expected 80000000 0", mem[64], busy); end
    $display("[TB] test_launch done");
  endtask

  task automatic test_no_pending();
    do_reset();
    mem[64] = 32'h8000_0000;
    pb_delay = 4;
    scan_en = 1'b1;
    repeat (24) tick();
    scan_en = 1'b0;
    for (int k = 0; k < 10 && busy; k++) tick();
    tests++; if (obs_launch.size() != 0 || obs_wr.size() != 0) begin errors++; $display("FAIL no_pending_events: launches %0d writes %0d expected 0 0", obs_launch.size(), obs_wr.size()); end
    tests++; if (sent_count !== 16'd0 || mem[64] !== 32'h8000_0000) begin errors++; $display("FAIL no_pending_state: sent %0d mem %h expected 0 80000000", sent_count, mem[64]); end
    $display("[TB] test_no_pending done");
  endtask

  task automatic test_host_wait();
    int l, g;
    logic [31:0] d;
    do_reset();
    mem[64] = 32'hC000_0000;
    mem[300] = 32'hDEAD_BEEF;
    pb_delay = 10;
    scan_en = 1'b1;
    for (int k = 0; k < 50 && obs_launch.size() == 0; k++) tick();
    l = (obs_launch.size() > 0) ? obs_launch_cyc[0] : cyc;
    host_req = 1'b1;
    host_addr = 9'd300;
    host_wren = 1'b0;
    exp_hrd.push_back(32'hDEAD_BEEF);
    g = -1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (host_gnt) begin
        g = cyc;
        tests++; if (ram_addr !== 9'd300 || ram_wren !== 1'b0) begin errors++; $display("FAIL host_grant_port: addr %0d wren %b expected 300 0", ram_addr, ram_wren); end
        break;
      end
    end
    tick();
    host_req = 1'b0;
    tests++; if (g != l + 12) begin errors++; $display("FAIL host_grant_time: got cycle %0d expected %0d", g, l + 12); end
    tests++;
    if (obs_hrd.size() != 1) begin
      errors++; $display("FAIL host_rvalid_count: got %0d expected 1", obs_hrd.size());
    end else begin
      d = exp_hrd.pop_front();
      tests++; if (obs_hrd[0] !== d) begin errors++; $display("FAIL host_read_data: got %h expected %h", obs_hrd[0], d); end
      tests++; if (obs_hrd_cyc[0] != g + 1) begin errors++; $display("FAIL host_rvalid_time: got cycle %0d expected %0d", obs_hrd_cyc[0], g + 1); end
    end
    scan_en = 1'b0;
    for (int k = 0; k < 50 && busy; k++) tick();
    tests++; if (busy !== 1'b0 || host_rvalid !== 1'b0) begin errors++; $display("FAIL host_wait_end: busy %b rvalid %b expected 0 0", busy, host_rvalid); end
    $display("[TB] test_host_wait done");
  endtask

  task automatic test_host_idle_write();
    do_reset();
    host_req = 1'b1;
    host_addr = 9'd5;
    host_wdata = 32'h0000_1234;
    host_wren = 1'b1;
    tick();
    tests++; if (host_gnt !== 1'b1 || ram_wren !== 1'b1 || ram_addr !== 9'd5 || ram_wdata !== 32'h1234) begin
      errors++; $display("FAIL host_idle_write_port: gnt %b wren %b addr %0d wdata %h expected 1 1 5 1234", host_gnt, ram_wren, ram_addr, ram_wdata);
    end
    tick();
    host_req = 1'b0;
    host_wren = 1'b0;
    tests++; if (mem[5] !== 32'h0000_1234 || host_rvalid !== 1'b0) begin errors++; $display("FAIL host_idle_write_result: mem %h rvalid %b expected 1234 0", mem[5], host_rvalid); end
    $display("[TB] test_host_idle_write done");
  endtask

  task automatic test_timeout();
    int l;
    do_reset();
    mem[32] = 32'hC000_0000;
    pb_delay = 0;
    exp_launch.push_back(8'd32);
    exp_launch.push_back(8'd32);
    scan_en = 1'b1;
    for (int k = 0; k < 50 && obs_launch.size() == 0; k++) tick();
    l = (obs_launch.size() > 0) ? obs_launch_cyc[0] : cyc;
    repeat (255) tick();
    tests++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_early: terr %b expected 0 at last WAIT_PB cycle", timeout_err); end
    tick();
    tests++; if (timeout_err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL timeout_set: terr %b busy %b expected 1 1", timeout_err, busy); end
    for (int k = 0; k < 100 && obs_launch.size() < 2; k++) tick();
    scan_en = 1'b0;
    tests++;
    if (obs_launch.size() != 2) begin
      errors++; $display("FAIL timeout_relaunch_count: got %0d expected 2", obs_launch.size());
    end else begin
      tests++; if (obs_launch[0] !== exp_launch[0] || obs_launch[1] !== exp_launch[1]) begin errors++; $display("FAIL timeout_relaunch_base: got %0d %0d expected 32 32", obs_launch[0], obs_launch[1]); end
      tests++; if (obs_launch_cyc[1] != l + 280) begin errors++; $display("FAIL timeout_relaunch_time: got cycle %0d expected %0d", obs_launch_cyc[1], l + 280); end
    end
    for (int k = 0; k < 400 && busy; k++) tick();
    tests++; if (obs_wr.size() != 0 || mem[32] !== 32'hC000_0000 || sent_count !== 16'd0) begin
      errors++; $display("FAIL timeout_no_clear: writes %0d mem %h sent %0d expected 0 c0000000 0", obs_wr.size(), mem[32], sent_count);
    end
    tests++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL timeout_sticky: terr %b busy %b expected 1 0", timeout_err, busy); end
    $display("[TB] test_timeout done");
  endtask

  task automatic test_reset_mid();
    int c;
    logic [40:0] w;
    do_reset();
    mem[64] = 32'hC000_0000;
    pb_delay = 0;
    scan_en = 1'b1;
    for (int k = 0; k < 50 && obs_launch.size() == 0; k++) tick();
    repeat (5) tick();
    reset = 1'b1;
    tick();
    tests++; if (busy !== 1'b0 || pb_start !== 1'b0 || ram_wren !== 1'b0 || host_rvalid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_ctrl: busy %b pb_start %b wren %b rvalid %b expected 0 0 0 0", busy, pb_start, ram_wren, host_rvalid);
    end
    tests++; if (ram_addr !== 9'd0 || pb_base !== 8'd0 || sent_count !== 16'd0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL reset_mid_values: addr %0d pb_base %0d sent %0d terr %b expected 0 0 0 0", ram_addr, pb_base, sent_count, timeout_err);
    end
    tests++; if (mem[64] !== 32'hC000_0000) begin errors++; $display("FAIL reset_mid_pending: mem %h expected c0000000", mem[64]); end
    obs_launch.delete(); obs_launch_cyc.delete();
    reset = 1'b0;
    pb_delay = 3;
    c = cyc;
    exp_launch.push_back(8'd64);
    exp_wr.push_back({9'd64, 32'h8000_0000});
    for (int k = 0; k < 50 && obs_wr.size() == 0; k++) tick();
    scan_en = 1'b0;
    tests++;
    if (obs_launch.size() != 1 || obs_wr.size() != 1) begin
      errors++; $display("FAIL reset_mid_relaunch: launches %0d writes %0d expected 1 1", obs_launch.size(), obs_wr.size());
    end else begin
      tests++; if (obs_launch[0] !== exp_launch.pop_front() || obs_launch_cyc[0] != c + 9) begin
        errors++; $display("FAIL reset_mid_first_launch: base %0d cycle %0d expected 64 %0d", obs_launch[0], obs_launch_cyc[0], c + 9);
      end
      w = exp_wr.pop_front();
      tests++; if (obs_wr[0] !== w || obs_wr_cyc[0] - obs_launch_cyc[0] != 4) begin
        errors++; $display("FAIL reset_mid_clear: got %h after %0d expected %h after 4", obs_wr[0], obs_wr_cyc[0] - obs_launch_cyc[0], w);
      end
    end
    for (int k = 0; k < 10 && busy; k++) tick();
    tests++; if (sent_count !== 16'd1) begin errors++; $display("FAIL reset_mid_sent: got %0d expected 1", sent_count); end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    pb_done = 1'b0;
    test_reset();
    test_empty_lap();
    test_launch();
    test_no_pending();
    test_host_wait();
    test_host_idle_write();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
